// File: rtl/uart_apb_bridge_if.sv
// uart_apb_bridge_if: UART byte handshake and APB requester signals of the bridge.
interface uart_apb_bridge_if #(parameter int ADDR_WIDTH = 16, parameter int DATA_WIDTH = 32);
  logic rx_en;
  logic [7:0] rx_data;
  logic tx_en;
  logic [7:0] tx_data;
  logic tx_done;
  logic [ADDR_WIDTH-1:0] paddr;
  logic psel;
  logic penable;
  logic pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic pready;
  logic pslverr;
  logic rx_overrun;
  modport master(input rx_en, rx_data, tx_done, prdata, pready, pslverr,
                 output tx_en, tx_data, paddr, psel, penable, pwrite, pwdata, rx_overrun);
  modport slave(output rx_en, rx_data, tx_done, prdata, pready, pslverr,
                input tx_en, tx_data, paddr, psel, penable, pwrite, pwdata, rx_overrun);
endinterface

// File: rtl/uart_apb_bridge.sv
// uart_apb_bridge: UART command frames -> one APB transfer each, status/read data sent back.
// Define UART_APB_BRIDGE_RX_TIMEOUT_EN to discard partial frames after RX_TIMEOUT silent cycles.
module uart_apb_bridge #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int APB_TIMEOUT = 255,
  parameter int RX_TIMEOUT = 100000
) (
  input logic clk,
  input logic reset,
  uart_apb_bridge_if.master bus
);
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, SETUP, ACCESS, RESP, RESP_WAIT} state_t;
  localparam logic [7:0] TMO_LAST = 8'(APB_TIMEOUT - 1);
  if (ADDR_WIDTH != 16 || DATA_WIDTH != 32 || RX_TIMEOUT < 1) begin : g_bad_cfg
    $error("uart_apb_bridge: unsupported parameters");
  end
  state_t state_q, state_d, st;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] tmo_q, tmo_d, tx_data_q, tx_data_d;
  logic [2:0] left_q, left_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d, rdata_q, rdata_d;
  logic psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic tx_en_q, tx_en_d, ovr_q, ovr_d;
`ifdef UART_APB_BRIDGE_RX_TIMEOUT_EN
  localparam int RW = $clog2(RX_TIMEOUT + 1);
  logic [RW-1:0] rxt_q, rxt_d;
  logic rx_to;
  // An expiring partial frame is handled as IDLE this very cycle, so a coincident byte starts a new frame.
  assign rx_to = (state_q == ADDR || state_q == WDATA) && rxt_q == RW'(RX_TIMEOUT);
  assign rxt_d = ((state_d == ADDR || state_d == WDATA) && !bus.rx_en) ? rxt_q + RW'(1) : '0;
  assign st = rx_to ? IDLE : state_q;
`else
  assign st = state_q;
`endif
  always_comb begin
    state_d = st;
    cnt_d = cnt_q;
    tmo_d = tmo_q;
    left_d = left_q;
    paddr_d = paddr_q;
    pwdata_d = pwdata_q;
    rdata_d = rdata_q;
    tx_data_d = tx_data_q;
    psel_d = psel_q;
    penable_d = penable_q;
    pwrite_d = pwrite_q;
    tx_en_d = 1'b0;
    ovr_d = bus.rx_en && (state_q inside {SETUP, ACCESS, RESP, RESP_WAIT});
    case (st)
      IDLE: if (bus.rx_en) begin
        if (bus.rx_data == 8'h01 || bus.rx_data == 8'h02) begin
          pwrite_d = bus.rx_data[1];
          cnt_d = '0;
          state_d = ADDR;
        end else begin
          tx_data_d = 8'h03;
          tx_en_d = 1'b1;
          left_d = '0;
          state_d = RESP;
        end
      end
      ADDR: if (bus.rx_en) begin
        paddr_d = {bus.rx_data, paddr_q[ADDR_WIDTH-1:8]};
        cnt_d = cnt_q == 2'd1 ? 2'd0 : cnt_q + 2'd1;
        if (cnt_q == 2'd1) begin
          state_d = pwrite_q ? WDATA : SETUP;
          psel_d = !pwrite_q;
          tmo_d = '0;
        end
      end
      WDATA: if (bus.rx_en) begin
        pwdata_d = {bus.rx_data, pwdata_q[DATA_WIDTH-1:8]};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = SETUP;
          psel_d = 1'b1;
          tmo_d = '0;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d = ACCESS;
      end
      // pready is tested before the timeout, so it wins in the final counted cycle.
      ACCESS: if (bus.pready || tmo_q == TMO_LAST) begin
        psel_d = 1'b0;
        penable_d = 1'b0;
        tx_en_d = 1'b1;
        rdata_d = bus.prdata;
        tx_data_d = !bus.pready ? 8'h02 : bus.pslverr ? 8'h01 : 8'h00;
        left_d = (bus.pready && !bus.pslverr && !pwrite_q) ? 3'd4 : 3'd0;
        state_d = RESP;
      end else tmo_d = tmo_q + 8'd1;
      RESP: state_d = RESP_WAIT;
      RESP_WAIT: if (bus.tx_done) begin
        if (left_q != 3'd0) begin
          tx_data_d = rdata_q[7:0];
          rdata_d = rdata_q >> 8;
          left_d = left_q - 3'd1;
          tx_en_d = 1'b1;
          state_d = RESP;
        end else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      tmo_q <= '0;
      left_q <= '0;
      paddr_q <= '0;
      pwdata_q <= '0;
      rdata_q <= '0;
      tx_data_q <= '0;
      psel_q <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q <= 1'b0;
      tx_en_q <= 1'b0;
      ovr_q <= 1'b0;
`ifdef UART_APB_BRIDGE_RX_TIMEOUT_EN
      rxt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
      left_q <= left_d;
      paddr_q <= paddr_d;
      pwdata_q <= pwdata_d;
      rdata_q <= rdata_d;
      tx_data_q <= tx_data_d;
      psel_q <= psel_d;
      penable_q <= penable_d;
      pwrite_q <= pwrite_d;
      tx_en_q <= tx_en_d;
      ovr_q <= ovr_d;
`ifdef UART_APB_BRIDGE_RX_TIMEOUT_EN
      rxt_q <= rxt_d;
`endif
    end
  end
  assign bus.tx_en = tx_en_q;
  assign bus.tx_data = tx_data_q;
  assign bus.paddr = paddr_q;
  assign bus.psel = psel_q;
  assign bus.penable = penable_q;
  assign bus.pwrite = pwrite_q;
  assign bus.pwdata = pwdata_q;
  assign bus.rx_overrun = ovr_q;
endmodule

// File: doc/uart_apb_bridge.md
Name: uart_apb_bridge

Overview:
- Debug bridge that makes a UART byte stream act as an APB requester, the initiator end of the APB completer links used by the peripherals.
- Parses command frames from the UART receiver's byte output and issues one APB transfer per frame.
- Returns a status byte, plus read data when applicable, to the UART transmitter's byte input.
- Sits between the UART core and the peripheral APB fabric. It is the host-side path for poking registers such as the UART peripheral's STATUS/CLK_DIV.

Parameters:
- ADDR_WIDTH, 16, APB paddr width; must be 16 (two address bytes).
- DATA_WIDTH, 32, APB data width; must be 32 (four data bytes).
- APB_TIMEOUT, 255, maximum ACCESS-phase cycles waiting for pready before abort.
- RX_TIMEOUT, 100000, cycles of inter-byte silence before a partial frame is discarded (optional feature only).

Ports:
- clk  in  1  single clock, also the APB pclk.
- reset  in  1  asynchronous, active-high reset.
- rx_en  in  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  in  8  received byte.
- tx_en  out  1  one-cycle strobe: start sending tx_data.
- tx_data  out  8  byte to transmit; held stable until tx_done.
- tx_done  in  1  one-cycle strobe: transmitter finished the current byte.
- paddr  out  16  APB address.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  32  APB write data.
- prdata  in  32  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB error.
- rx_overrun  out  1  one-cycle pulse: a byte arrived while the bridge was not accepting and was dropped.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; byte counters 0. Reset mid-transfer drops psel/penable immediately and discards the frame; no response is sent.
- Frame format (multi-byte fields sent LSB first):
  - Command byte: 0x01 = read, 0x02 = write.
  - Address: 2 bytes.
  - Data: 4 bytes, write frames only.
- Response frame: status byte, then 4 prdata bytes (LSB first) for successful reads only.
  - 0x00 = OK
  - 0x01 = pslverr
  - 0x02 = APB timeout
  - 0x03 = bad command
- FSM states: IDLE, ADDR, WDATA, SETUP, ACCESS, RESP, RESP_WAIT.
  - IDLE: rx_en with 0x01/0x02 latches pwrite and goes to ADDR. Any other byte: status 0x03, go to RESP.
  - ADDR: collects 2 bytes into paddr. Then write → WDATA, read → SETUP.
  - WDATA: collects 4 bytes into pwdata, then SETUP.
  - SETUP: exactly one cycle with psel=1, penable=0, then ACCESS.
  - ACCESS: psel=1, penable=1.
    - On pready: latch prdata/pslverr; next cycle psel=penable=0; go to RESP.
    - If APB_TIMEOUT cycles elapse in ACCESS without pready: drop psel/penable, status 0x02, go to RESP.
    - pready in the same cycle the timeout count expires: pready wins.
  - RESP: tx_en=1 for one cycle with tx_data = next response byte, then RESP_WAIT.
  - RESP_WAIT: on tx_done, return to RESP if response bytes remain, else IDLE.
- First APB setup cycle occurs 1 cycle after the strobe of the final frame byte. First tx_en occurs 1 cycle after the pready cycle.
- paddr, pwrite and pwdata stay stable from SETUP through the end of ACCESS.
- rx_en in SETUP, ACCESS, RESP or RESP_WAIT: byte dropped, rx_overrun pulses the following cycle.
- Timeout counter is 8 bits wide, saturating at APB_TIMEOUT, and is cleared on entry to SETUP.
- tx_done outside RESP_WAIT is ignored.

Optional Feature:
- Macro: UART_APB_BRIDGE_RX_TIMEOUT_EN.
- Defined:
  - A counter runs in ADDR/WDATA, reset on each rx_en.
  - When it reaches RX_TIMEOUT, the partial frame is discarded and the FSM returns to IDLE with no APB transfer and no response.
  - rx_en arriving in the same cycle as the timeout is treated as a new command byte in IDLE.
- Not defined: a partial frame waits forever; no counter logic is synthesized.

Test Plan:
- Read: rx bytes 01 04 00 -> one APB read with paddr=0x0004, psel=1/penable=0 for exactly 1 cycle. Completer returns prdata=0x00001234 after 2 wait states -> tx bytes 00 34 12 00 00, each sent only after the previous byte's tx_done.
- Write: rx bytes 02 08 00 41 00 00 00 -> APB write with paddr=0x0008, pwdata=0x00000041; pready with pslverr=1 -> single tx byte 01.
- Timeout: read of 0x0010, pready held low -> psel drops after 255 ACCESS cycles; tx byte 02. Repeat with pready in cycle 255 -> status 00.
- Bad command and overrun:
  - rx byte 0x7F -> tx byte 03, no psel activity.
  - Inject an rx byte during ACCESS -> rx_overrun pulses once; the resulting APB transfer is unaffected.
- Reset: assert reset during ACCESS -> psel/penable/tx_en low in the same cycle. A following read command works normally.
- With UART_APB_BRIDGE_RX_TIMEOUT_EN and RX_TIMEOUT=50: rx bytes 01 04, then 60 idle cycles, then 01 0C 00 -> exactly one APB read, to 0x000C.
